// File: rtl/avr_tx_arbiter.sv
// Arbiter that lets two byte-stream sources share the single avr_interface TX channel.
// A granted source keeps the channel for a whole message. Round-robin, burst limit and idle timeout hand it over.
module avr_tx_arbiter #(
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 5000,
  parameter int HOLDOFF   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] tx_data0,
  input  logic       new_tx_data0,
  output logic       tx_busy0,
  input  logic       req1,
  input  logic [7:0] tx_data1,
  input  logic       new_tx_data1,
  output logic       tx_busy1,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant
);

  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);
  localparam logic [TW-1:0] TIME_LIM  = TW'(TIMEOUT);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state;
  logic          last_served;
  logic [BW-1:0] byte_cnt;
  logic [TW-1:0] idle_cnt;
  logic [HW-1:0] holdoff;

  logic owner_req;
  logic accept0;
  logic accept1;
  logic accept;
  logic burst_hit;
  logic time_hit;
  logic release_now;

  // The downstream busy passes straight through, so a source never strobes into a busy channel.
  assign tx_busy0 = (state != GRANT0) || tx_busy || (holdoff != {HW{1'b0}});
  assign tx_busy1 = (state != GRANT1) || tx_busy || (holdoff != {HW{1'b0}});

  assign accept0 = (state == GRANT0) && new_tx_data0 && !tx_busy0;
  assign accept1 = (state == GRANT1) && new_tx_data1 && !tx_busy1;
  assign accept  = accept0 || accept1;

  assign burst_hit = (MAX_BURST != 0) && (byte_cnt == BURST_LIM);
  assign time_hit  = (TIMEOUT != 0) && (idle_cnt == TIME_LIM);

  always_comb begin
    owner_req = 1'b0;
    if (state == GRANT0) begin
      owner_req = req0;
    end else if (state == GRANT1) begin
      owner_req = req1;
    end else begin
      owner_req = 1'b0;
    end
  end

  // Release waits for the channel to go quiet, so a byte in flight is never cut off. A same-cycle accept takes priority.
  assign release_now = ((state == GRANT0) || (state == GRANT1)) &&
                       (holdoff == {HW{1'b0}}) && !tx_busy && !accept &&
                       (!owner_req || burst_hit || time_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 2'b00;
      tx_data     <= 8'h00;
      new_tx_data <= 1'b0;
      last_served <= 1'b1;
      byte_cnt    <= {BW{1'b0}};
      idle_cnt    <= {TW{1'b0}};
      holdoff     <= {HW{1'b0}};
    end else begin
      new_tx_data <= accept;
      if (accept0) begin
        tx_data <= tx_data0;
      end else if (accept1) begin
        tx_data <= tx_data1;
      end else begin
        tx_data <= tx_data;
      end

      if (accept) begin
        holdoff <= HOLD_LOAD;
      end else if (holdoff != {HW{1'b0}}) begin
        holdoff <= holdoff - 1'b1;
      end else begin
        holdoff <= holdoff;
      end

      case (state)
        IDLE: begin
          byte_cnt <= {BW{1'b0}};
          idle_cnt <= {TW{1'b0}};
          // On a tie, the requester that was not served last wins.
          if (req0 && req1) begin
            if (last_served) begin
              state <= GRANT0;
              grant <= 2'b01;
            end else begin
              state <= GRANT1;
              grant <= 2'b10;
            end
          end else if (req0) begin
            state <= GRANT0;
            grant <= 2'b01;
          end else if (req1) begin
            state <= GRANT1;
            grant <= 2'b10;
          end else begin
            state <= IDLE;
            grant <= 2'b00;
          end
        end
        GRANT0, GRANT1: begin
          if (release_now) begin
            state       <= RELEASE;
            grant       <= 2'b00;
            last_served <= (state == GRANT1);
          end else if (accept) begin
            idle_cnt <= {TW{1'b0}};
            if ((MAX_BURST != 0) && (byte_cnt != BURST_LIM)) begin
              byte_cnt <= byte_cnt + 1'b1;
            end else begin
              byte_cnt <= byte_cnt;
            end
          end else begin
            if ((TIMEOUT != 0) && (idle_cnt != TIME_LIM)) begin
              idle_cnt <= idle_cnt + 1'b1;
            end else begin
              idle_cnt <= idle_cnt;
            end
          end
        end
        RELEASE: begin
          state <= IDLE;
          grant <= 2'b00;
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avr_tx_arbiter.sv
// Self-checking bench for avr_tx_arbiter: directed scenarios plus random traffic
// compared against a rule-level reference model.
module tb_avr_tx_arbiter;

  localparam int MB = 4;
  localparam int TO = 10;
  localparam int HO = 2;

  logic       clk;
  logic       rst;
  logic       req0, new_tx_data0, tx_busy0;
  logic [7:0] tx_data0;
  logic       req1, new_tx_data1, tx_busy1;
  logic [7:0] tx_data1;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;
  logic [1:0] grant;

  int checks = 0;
  int passed = 0;
  int bcnt;

  avr_tx_arbiter #(.MAX_BURST(MB), .TIMEOUT(TO), .HOLDOFF(HO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .tx_data0(tx_data0), .new_tx_data0(new_tx_data0), .tx_busy0(tx_busy0),
    .req1(req1), .tx_data1(tx_data1), .new_tx_data1(new_tx_data1), .tx_busy1(tx_busy1),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy), .grant(grant)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Downstream avr_interface stand-in: busy for 3 cycles, starting 1 cycle after each strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) bcnt <= 0;
    else if (new_tx_data) bcnt <= 3;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end

  // Reference model: owner index, phase (0 idle, 1 granted, 2 release) and plain counters.
  int         m_owner = -1;
  int         m_phase = 0;
  int         m_last  = 1;
  int         m_bytes = 0;
  int         m_quiet = 0;
  int         m_hold  = 0;
  logic       m_new   = 1'b0;
  logic [7:0] m_data  = 8'h00;

  function automatic logic m_busy(input int n);
    return !(m_phase == 1 && m_owner == n) || tx_busy || (m_hold > 0);
  endfunction

  function automatic logic [1:0] m_grant();
    if (m_phase != 1) return 2'b00;
    return (m_owner == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic m_reset();
    m_owner = -1; m_phase = 0; m_last = 1; m_bytes = 0;
    m_quiet = 0; m_hold = 0; m_new = 1'b0; m_data = 8'h00;
  endtask

  task automatic advance();
    logic a0, a1, acc, oreq, rel;
    a0   = (m_phase == 1) && (m_owner == 0) && new_tx_data0 && !m_busy(0);
    a1   = (m_phase == 1) && (m_owner == 1) && new_tx_data1 && !m_busy(1);
    acc  = a0 || a1;
    oreq = (m_owner == 0) ? req0 : req1;
    rel  = (m_phase == 1) && (m_hold == 0) && !tx_busy && !acc &&
           (!oreq || (m_bytes == MB) || (m_quiet == TO));
    m_new = acc;
    if (a0) m_data = tx_data0;
    if (a1) m_data = tx_data1;
    if (acc) m_hold = HO;
    else if (m_hold > 0) m_hold = m_hold - 1;
    if (m_phase == 0) begin
      if (req0 || req1) begin
        if (req0 && req1) m_owner = (m_last == 0) ? 1 : 0;
        else m_owner = req0 ? 0 : 1;
        m_phase = 1; m_bytes = 0; m_quiet = 0;
      end
    end else if (m_phase == 1) begin
      if (rel) begin
        m_phase = 2; m_last = m_owner;
      end else if (acc) begin
        m_quiet = 0;
        if (m_bytes < MB) m_bytes = m_bytes + 1;
      end else if (m_quiet < TO) begin
        m_quiet = m_quiet + 1;
      end
    end else begin
      m_phase = 0; m_owner = -1;
    end
  endtask

  task automatic drive(input logic r0, input logic s0, input logic [7:0] d0,
                       input logic r1, input logic s1, input logic [7:0] d1, input logic b);
    @(negedge clk);
    req0 = r0; new_tx_data0 = s0; tx_data0 = d0;
    req1 = r1; new_tx_data1 = s1; tx_data1 = d1;
    tx_busy = b;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0; new_tx_data0 = 1'b0; tx_data0 = 8'h00;
    req1 = 1'b0; new_tx_data1 = 1'b0; tx_data1 = 8'h00;
    tx_busy = 1'b0;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (grant !== 2'b00) $display("FAIL reset_grant got %b want 00", grant); else passed++;
    checks++; if (new_tx_data !== 1'b0) $display("FAIL reset_new got %b want 0", new_tx_data); else passed++;
    checks++; if (tx_data !== 8'h00) $display("FAIL reset_data got %h want 00", tx_data); else passed++;
    checks++; if ({tx_busy0, tx_busy1} !== 2'b11) $display("FAIL reset_busy got %b want 11", {tx_busy0, tx_busy1}); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_source();
    logic [7:0] bytes [3];
    int k, got;
    logic p_b0, p_s0, s0;
    bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
    k = 0; got = 0; p_b0 = 1'b1; p_s0 = 1'b0;
    do_reset();
    for (int c = 0; c < 80 && got < 3; c++) begin
      s0 = (k < 3) && !p_b0 && !p_s0;
      drive(1'b1, s0, s0 ? bytes[k] : 8'h00, 1'b0, 1'b0, 8'h00, bcnt > 0);
      if (s0) k++;
      checks++; if (new_tx_data !== p_s0) $display("FAIL single_strobe cycle %0d got %b want %b", c, new_tx_data, p_s0); else passed++;
      if (new_tx_data === 1'b1 && got < 3) begin
        checks++; if (tx_data !== bytes[got]) $display("FAIL single_data got %h want %h", tx_data, bytes[got]); else passed++;
        got++;
      end
      if (c > 0) begin
        checks++; if (grant !== 2'b01) $display("FAIL single_grant cycle %0d got %b want 01", c, grant); else passed++;
      end
      checks++; if (tx_busy1 !== 1'b1) $display("FAIL single_busy1 got %b want 1", tx_busy1); else passed++;
      p_b0 = tx_busy0; p_s0 = s0;
    end
    checks++; if (got !== 3) $display("FAIL single_count got %0d want 3", got); else passed++;
  endtask

  task automatic test_tie_and_handover();
    int zeros;
    logic seen;
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (grant !== 2'b00) $display("FAIL tie_first got %b want 00", grant); else passed++;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      checks++; if (grant !== 2'b01) $display("FAIL tie_grant0 got %b want 01", grant); else passed++;
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (grant !== 2'b01) $display("FAIL drop_same_cycle got %b want 01", grant); else passed++;
    zeros = 0; seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      if (grant === 2'b10) seen = 1'b1;
      else if (grant === 2'b00) zeros++;
    end
    checks++; if (!seen) $display("FAIL handover_grant1 got %b want 10", grant); else passed++;
    checks++; if (zeros !== 2) $display("FAIL handover_gap got %0d want 2", zeros); else passed++;
  endtask

  task automatic test_burst_alternate();
    int order[$];
    logic p_b0, p_s0, p_b1, p_s1, s0, s1;
    int n0, n1;
    p_b0 = 1'b1; p_s0 = 1'b0; p_b1 = 1'b1; p_s1 = 1'b0; n0 = 0; n1 = 0;
    do_reset();
    for (int c = 0; c < 800 && order.size() < 16; c++) begin
      s0 = !p_b0 && !p_s0;
      s1 = !p_b1 && !p_s1;
      drive(1'b1, s0, {1'b0, 7'(n0)}, 1'b1, s1, {1'b1, 7'(n1)}, bcnt > 0);
      if (s0) n0++;
      if (s1) n1++;
      p_b0 = tx_busy0; p_s0 = s0; p_b1 = tx_busy1; p_s1 = s1;
      if (new_tx_data === 1'b1) order.push_back(int'(tx_data[7]));
    end
    checks++; if (order.size() !== 16) $display("FAIL burst_count got %0d want 16", order.size()); else passed++;
    for (int i = 0; i < order.size(); i++) begin
      checks++;
      if (order[i] !== (i / MB) % 2) $display("FAIL burst_owner byte %0d got %0d want %0d", i, order[i], (i / MB) % 2);
      else passed++;
    end
  endtask

  task automatic test_foreign_strobe();
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (grant !== 2'b01) $display("FAIL foreign_grant got %b want 01", grant); else passed++;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0);
    checks++; if (tx_busy1 !== 1'b1) $display("FAIL foreign_busy1 got %b want 1", tx_busy1); else passed++;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      checks++; if (new_tx_data !== 1'b0) $display("FAIL foreign_dropped got %b want 0", new_tx_data); else passed++;
    end
  endtask

  task automatic test_timeout();
    int n01, n00;
    logic seen;
    n01 = 0; n00 = 0; seen = 1'b0;
    do_reset();
    for (int c = 0; c < 60 && !seen; c++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      if (grant === 2'b01) n01++;
      else if (grant === 2'b10) seen = 1'b1;
      else if (n01 > 0) n00++;
    end
    checks++; if (n01 !== TO + 1) $display("FAIL timeout_len got %0d want %0d", n01, TO + 1); else passed++;
    checks++; if (n00 !== 2) $display("FAIL timeout_gap got %0d want 2", n00); else passed++;
    checks++; if (!seen) $display("FAIL timeout_next got %b want 10", grant); else passed++;
  endtask

  task automatic test_reset_mid_byte();
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (new_tx_data !== 1'b1) $display("FAIL midreset_pre got %b want 1", new_tx_data); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (grant !== 2'b00) $display("FAIL midreset_grant got %b want 00", grant); else passed++;
    checks++; if (new_tx_data !== 1'b0) $display("FAIL midreset_new got %b want 0", new_tx_data); else passed++;
    checks++; if ({tx_busy0, tx_busy1} !== 2'b11) $display("FAIL midreset_busy got %b want 11", {tx_busy0, tx_busy1}); else passed++;
    #2 rst = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++; if (grant !== 2'b01) $display("FAIL midreset_tie got %b want 01", grant); else passed++;
  endtask

  task automatic test_random();
    logic r0, r1;
    r0 = 1'b0; r1 = 1'b0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) r0 = ~r0;
      if ($urandom_range(7) == 0) r1 = ~r1;
      drive(r0, $urandom_range(9) < 4, 8'($urandom), r1, $urandom_range(9) < 4, 8'($urandom),
            $urandom_range(3) == 0);
      checks++; if (grant !== m_grant()) $display("FAIL rnd_grant cycle %0d got %b want %b", i, grant, m_grant()); else passed++;
      checks++; if (new_tx_data !== m_new) $display("FAIL rnd_new cycle %0d got %b want %b", i, new_tx_data, m_new); else passed++;
      if (m_new) begin
        checks++; if (tx_data !== m_data) $display("FAIL rnd_data cycle %0d got %h want %h", i, tx_data, m_data); else passed++;
      end
      checks++; if (tx_busy0 !== m_busy(0)) $display("FAIL rnd_busy0 cycle %0d got %b want %b", i, tx_busy0, m_busy(0)); else passed++;
      checks++; if (tx_busy1 !== m_busy(1)) $display("FAIL rnd_busy1 cycle %0d got %b want %b", i, tx_busy1, m_busy(1)); else passed++;
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; new_tx_data0 = 1'b0; tx_data0 = 8'h00;
    req1 = 1'b0; new_tx_data1 = 1'b0; tx_data1 = 8'h00;
    tx_busy = 1'b0;
    test_reset();
    test_single_source();
    test_tie_and_handover();
    test_burst_alternate();
    test_foreign_strobe();
    test_timeout();
    test_reset_mid_byte();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
